// File: rtl/sc1_boot_ctrl_if.sv
// sc1_boot_ctrl_if: bundles the host load stream, the CPU fetch port, the
// instruction-memory port and the status outputs of the boot controller.
//
// Load handshake: a word transfers on a rising clk edge where load_valid and
// load_ready are both 1. load_ready depends only on controller state, never
// on load_valid. load_data and load_last are meaningful only while load_valid
// is 1. The host may present load_valid at any time; the word is taken only
// when load_ready is also high.
interface sc1_boot_ctrl_if #(
  parameter int DEPTH_I = 8
);
  logic               load_req;
  logic               load_valid;
  logic [31:0]        load_data;
  logic               load_last;
  logic               load_ready;
  logic               cpu_reset;
  logic [DEPTH_I-1:0] cpu_rom_addr;
  logic [31:0]        cpu_rom_data;
  logic [DEPTH_I-1:0] mem_addr;
  logic               mem_we;
  logic [31:0]        mem_wdata;
  logic [31:0]        mem_rdata;
  logic               overflow;
  logic [31:0]        checksum;
  logic [1:0]         dbg_state;  // 0 WAIT, 1 RUN, 2 LOAD, 3 RESTART

  // Controller side
  modport slave (
    input  load_req, load_valid, load_data, load_last, cpu_rom_addr, mem_rdata,
    output load_ready, cpu_reset, cpu_rom_data, mem_addr, mem_we, mem_wdata,
           overflow, checksum, dbg_state
  );

  // Host / CPU / memory side
  modport master (
    output load_req, load_valid, load_data, load_last, cpu_rom_addr, mem_rdata,
    input  load_ready, cpu_reset, cpu_rom_data, mem_addr, mem_we, mem_wdata,
           overflow, checksum, dbg_state
  );
endinterface

// File: rtl/sc1_boot_ctrl.sv
// sc1_boot_ctrl: holds the CPU in reset after power-on, then either lets it
// run from instruction memory or loads a new program from the host stream and
// restarts the CPU.
// Optional feature: define SC1_BOOT_CHECKSUM_EN to build the running sum of
// loaded words on the checksum output; otherwise checksum is tied to 0.
module sc1_boot_ctrl #(
  parameter int DEPTH_I         = 8,
  parameter int RESET_TIMER_BIT = 22,
  parameter int RESTART_CYCLES  = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  sc1_boot_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_WAIT    = 2'd0,
    ST_RUN     = 2'd1,
    ST_LOAD    = 2'd2,
    ST_RESTART = 2'd3
  } state_t;

  localparam logic [DEPTH_I-1:0]       PTR_MAX      = '1;
  localparam logic [DEPTH_I-1:0]       PTR_ONE      = DEPTH_I'(1);
  localparam logic [RESET_TIMER_BIT:0] TIMER_ONE    = (RESET_TIMER_BIT+1)'(1);
  localparam logic [7:0]               RESTART_LOAD = 8'(RESTART_CYCLES - 1);

  logic [1:0]               sync_q;
  logic                     run_en;
  state_t                   state_q;
  logic [RESET_TIMER_BIT:0] timer_q;
  logic [RESET_TIMER_BIT:0] timer_d;
  logic [DEPTH_I-1:0]       ptr_q;
  logic                     ovf_q;
  logic                     cpu_reset_q;
  logic [7:0]               rcnt_q;
  logic                     load_enter;
  logic                     accept;

  // Reset assertion is immediate; release is re-timed through two flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= 2'b00;
    else          sync_q <= {sync_q[0], 1'b1};
  end

  assign run_en     = sync_q[1];
  assign timer_d    = timer_q + TIMER_ONE;
  // Any state other than LOAD moves to LOAD when the host requests it.
  assign load_enter = run_en && (state_q != ST_LOAD) && bus.load_req;
  assign accept     = (state_q == ST_LOAD) && bus.load_valid;

  // Main sequencer: state, power-on timer, write pointer, overflow, CPU reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_WAIT;
      timer_q     <= '0;
      ptr_q       <= '0;
      ovf_q       <= 1'b0;
      cpu_reset_q <= 1'b1;
      rcnt_q      <= '0;
    end else if (run_en) begin
      if (state_q == ST_WAIT) timer_q <= timer_d;
      if (load_enter) begin
        state_q     <= ST_LOAD;
        ptr_q       <= '0;
        ovf_q       <= 1'b0;
        cpu_reset_q <= 1'b1;
      end else begin
        case (state_q)
          ST_WAIT: begin
            if (timer_d[RESET_TIMER_BIT]) begin
              state_q     <= ST_RUN;
              cpu_reset_q <= 1'b0;
            end
          end
          ST_RUN: begin
            cpu_reset_q <= 1'b0;
          end
          ST_LOAD: begin
            if (bus.load_valid) begin
              ptr_q <= ptr_q + PTR_ONE;
              // Filling the last slot without finishing means later words wrap.
              if ((ptr_q == PTR_MAX) && !bus.load_last) ovf_q <= 1'b1;
              if (bus.load_last) begin
                state_q <= ST_RESTART;
                rcnt_q  <= RESTART_LOAD;
              end
            end
          end
          ST_RESTART: begin
            if (rcnt_q == 8'd0) begin
              state_q     <= ST_RUN;
              cpu_reset_q <= 1'b0;
            end else begin
              rcnt_q <= rcnt_q - 8'd1;
            end
          end
          default: begin
            state_q     <= ST_WAIT;
            cpu_reset_q <= 1'b1;
          end
        endcase
      end
    end
  end

`ifdef SC1_BOOT_CHECKSUM_EN
  logic [31:0] csum_q;

  // Running sum of accepted words, restarted on every load entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        csum_q <= '0;
    else if (load_enter) csum_q <= '0;
    else if (accept)     csum_q <= csum_q + bus.load_data;
  end

  assign bus.checksum = csum_q;
`else
  assign bus.checksum = 32'd0;
`endif

  // Memory port is owned by the CPU in RUN and by the load stream otherwise.
  assign bus.load_ready   = (state_q == ST_LOAD);
  assign bus.mem_we       = accept;
  assign bus.mem_addr     = (state_q == ST_RUN) ? bus.cpu_rom_addr : ptr_q;
  assign bus.mem_wdata    = (state_q == ST_LOAD) ? bus.load_data : 32'd0;
  assign bus.cpu_rom_data = (state_q == ST_RUN) ? bus.mem_rdata : 32'd0;
  assign bus.cpu_reset    = cpu_reset_q;
  assign bus.overflow     = ovf_q;
  assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_sc1_boot_ctrl.sv
// tb_sc1_boot_ctrl: directed bench for sc1_boot_ctrl with DEPTH_I=4,
// RESET_TIMER_BIT=4, RESTART_CYCLES=3 and a behavioural instruction memory.
module tb_sc1_boot_ctrl;

  localparam int DI = 4;
  localparam logic [1:0] S_WAIT = 2'd0, S_RUN = 2'd1, S_LOAD = 2'd2, S_RESTART = 2'd3;
`ifdef SC1_BOOT_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic clk;
  logic reset_n;
  int   n_tests;
  int   n_fail;

  logic [31:0]    mem [16];
  logic [35:0]    wr_q[$];
  logic [35:0]    exp_q[$];

  sc1_boot_ctrl_if #(.DEPTH_I(DI)) bus ();

  sc1_boot_ctrl #(
    .DEPTH_I(DI),
    .RESET_TIMER_BIT(4),
    .RESTART_CYCLES(3)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: synchronous read, one-cycle latency; also logs writes.
  always @(posedge clk) begin
    bus.mem_rdata <= mem[bus.mem_addr];
    if (bus.mem_we === 1'b1) begin
      mem[bus.mem_addr] = bus.mem_wdata;
      wr_q.push_back({bus.mem_addr, bus.mem_wdata});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] d, input logic last);
    n_tests++;
    if (bus.load_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL send_ready: load_ready=%b want 1", bus.load_ready);
    end
    bus.load_valid = 1'b1;
    bus.load_data  = d;
    bus.load_last  = last;
    tick();
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
    bus.load_data  = 32'd0;
  endtask

  task automatic enter_load();
    bus.load_req = 1'b1;
    tick();
    bus.load_req = 1'b0;
    n_tests++;
    if (bus.dbg_state !== S_LOAD || bus.cpu_reset !== 1'b1) begin
      n_fail++;
      $display("FAIL enter_load: state=%0d cpu_reset=%b want 2/1", bus.dbg_state, bus.cpu_reset);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    n_tests++;
    if (bus.cpu_reset !== 1'b1 || bus.load_ready !== 1'b0 || bus.mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: cpu_reset=%b load_ready=%b mem_we=%b want 1/0/0",
               bus.cpu_reset, bus.load_ready, bus.mem_we);
    end
    n_tests++;
    if (bus.overflow !== 1'b0 || bus.checksum !== 32'd0 || bus.dbg_state !== S_WAIT) begin
      n_fail++;
      $display("FAIL reset_status: overflow=%b checksum=%h state=%0d want 0/0/0",
               bus.overflow, bus.checksum, bus.dbg_state);
    end
    n_tests++;
    if (bus.cpu_rom_data !== 32'd0 || bus.mem_addr !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_mem: cpu_rom_data=%h mem_addr=%0d want 0/0", bus.cpu_rom_data, bus.mem_addr);
    end
  endtask

  task automatic test_power_on();
    int cnt;
    cnt = 0;
    reset_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.cpu_reset !== 1'b1) break;
      cnt++;
    end
    n_tests++;
    if (cnt < 16 || cnt > 18) begin
      n_fail++;
      $display("FAIL poweron_hold: cpu_reset held %0d cycles want 16..18", cnt);
    end
    n_tests++;
    if (bus.dbg_state !== S_RUN || bus.cpu_reset !== 1'b0) begin
      n_fail++;
      $display("FAIL poweron_run: state=%0d cpu_reset=%b want 1/0", bus.dbg_state, bus.cpu_reset);
    end
    bus.cpu_rom_addr = 4'd5;
    #1;
    n_tests++;
    if (bus.mem_addr !== 4'd5 || bus.mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL run_addr: mem_addr=%0d mem_we=%b want 5/0", bus.mem_addr, bus.mem_we);
    end
    tick();
    n_tests++;
    if (bus.cpu_rom_data !== 32'hCAFE0005) begin
      n_fail++;
      $display("FAIL run_fetch: cpu_rom_data=%h want cafe0005", bus.cpu_rom_data);
    end
  endtask

  task automatic test_load_basic();
    int cnt;
    bit rst_ok;
    wr_q.delete();
    exp_q.delete();
    enter_load();
    send_word(32'h11, 1'b0);
    n_tests++;
    if (bus.cpu_reset !== 1'b1 || bus.dbg_state !== S_LOAD) begin
      n_fail++;
      $display("FAIL load_hold: cpu_reset=%b state=%0d want 1/2", bus.cpu_reset, bus.dbg_state);
    end
    send_word(32'h22, 1'b0);
    send_word(32'h33, 1'b1);
    exp_q.push_back({4'd0, 32'h11});
    exp_q.push_back({4'd1, 32'h22});
    exp_q.push_back({4'd2, 32'h33});
    n_tests++;
    if (bus.dbg_state !== S_RESTART || bus.load_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL load_end: state=%0d load_ready=%b want 3/0", bus.dbg_state, bus.load_ready);
    end
    n_tests++;
    if (bus.checksum !== (CSUM_EN ? 32'h66 : 32'h0) || bus.overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL load_csum: checksum=%h overflow=%b want %h/0",
               bus.checksum, bus.overflow, CSUM_EN ? 32'h66 : 32'h0);
    end
    cnt = 0;
    rst_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (bus.dbg_state !== S_RESTART) break;
      if (bus.cpu_reset !== 1'b1) rst_ok = 1'b0;
      cnt++;
      tick();
    end
    n_tests++;
    if (cnt != 3 || !rst_ok) begin
      n_fail++;
      $display("FAIL restart_len: restart cycles=%0d cpu_reset_ok=%b want 3/1", cnt, rst_ok);
    end
    n_tests++;
    if (bus.dbg_state !== S_RUN || bus.cpu_reset !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_run: state=%0d cpu_reset=%b want 1/0", bus.dbg_state, bus.cpu_reset);
    end
    n_tests++;
    if (wr_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL basic_wr_count: writes=%0d want %0d", wr_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      n_tests++;
      if (wr_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL basic_wr[%0d]: got %h want %h", i, wr_q[i], exp_q[i]);
      end
    end
    bus.cpu_rom_addr = 4'd1;
    tick();
    n_tests++;
    if (bus.cpu_rom_data !== 32'h22) begin
      n_fail++;
      $display("FAIL basic_fetch: cpu_rom_data=%h want 22", bus.cpu_rom_data);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] sum;
    sum = 32'd0;
    wr_q.delete();
    exp_q.delete();
    enter_load();
    for (int i = 0; i < 17; i++) begin
      send_word(32'h100 + 32'(i), (i == 16));
      sum = sum + 32'h100 + 32'(i);
      exp_q.push_back({4'(i), 32'h100 + 32'(i)});
      if (i == 14) begin
        n_tests++;
        if (bus.overflow !== 1'b0) begin
          n_fail++;
          $display("FAIL ovf_early: overflow=%b want 0", bus.overflow);
        end
      end
    end
    n_tests++;
    if (bus.overflow !== 1'b1 || bus.checksum !== (CSUM_EN ? sum : 32'h0)) begin
      n_fail++;
      $display("FAIL ovf_set: overflow=%b checksum=%h want 1/%h",
               bus.overflow, bus.checksum, CSUM_EN ? sum : 32'h0);
    end
    n_tests++;
    if (wr_q.size() != 17) begin
      n_fail++;
      $display("FAIL ovf_wr_count: writes=%0d want 17", wr_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      n_tests++;
      if (wr_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL ovf_wr[%0d]: got %h want %h", i, wr_q[i], exp_q[i]);
      end
    end
    n_tests++;
    if (mem[0] !== 32'h110) begin
      n_fail++;
      $display("FAIL ovf_wrap_mem: mem[0]=%h want 110", mem[0]);
    end
    for (int i = 0; i < 20 && bus.dbg_state !== S_RUN; i++) tick();
    n_tests++;
    if (bus.dbg_state !== S_RUN || bus.overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_sticky: state=%0d overflow=%b want 1/1", bus.dbg_state, bus.overflow);
    end
  endtask

  task automatic test_gapped();
    bit rst_ok;
    wr_q.delete();
    exp_q.delete();
    enter_load();
    n_tests++;
    if (bus.overflow !== 1'b0 || bus.checksum !== 32'd0) begin
      n_fail++;
      $display("FAIL gap_clear: overflow=%b checksum=%h want 0/0", bus.overflow, bus.checksum);
    end
    for (int i = 0; i < 4; i++) begin
      send_word(32'hB0 + 32'(i), (i == 3));
      exp_q.push_back({4'(i), 32'hB0 + 32'(i)});
      if (i < 3) begin
        #1;
        n_tests++;
        if (bus.mem_we !== 1'b0) begin
          n_fail++;
          $display("FAIL gap_idle_we: mem_we=%b want 0", bus.mem_we);
        end
        tick();
      end
    end
    n_tests++;
    if (wr_q.size() != 4) begin
      n_fail++;
      $display("FAIL gap_wr_count: writes=%0d want 4", wr_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      n_tests++;
      if (wr_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL gap_wr[%0d]: got %h want %h", i, wr_q[i], exp_q[i]);
      end
    end
    // Request a new load while restarting.
    rst_ok = (bus.cpu_reset === 1'b1) && (bus.dbg_state === S_RESTART);
    tick();
    if (bus.cpu_reset !== 1'b1) rst_ok = 1'b0;
    bus.load_req = 1'b1;
    tick();
    bus.load_req = 1'b0;
    if (bus.cpu_reset !== 1'b1) rst_ok = 1'b0;
    n_tests++;
    if (bus.dbg_state !== S_LOAD || !rst_ok) begin
      n_fail++;
      $display("FAIL restart_reload: state=%0d cpu_reset_ok=%b want 2/1", bus.dbg_state, rst_ok);
    end
    send_word(32'h55, 1'b1);
    for (int i = 0; i < 20 && bus.dbg_state !== S_RUN; i++) tick();
    n_tests++;
    if (mem[0] !== 32'h55 || bus.dbg_state !== S_RUN) begin
      n_fail++;
      $display("FAIL reload_done: mem[0]=%h state=%0d want 55/1", mem[0], bus.dbg_state);
    end
  endtask

  task automatic test_reset_mid_load();
    bit rst_ok;
    enter_load();
    send_word(32'hA0, 1'b0);
    send_word(32'hA1, 1'b0);
    bus.load_valid = 1'b1;
    bus.load_data  = 32'hA2;
    reset_n = 1'b0;
    #1;
    n_tests++;
    if (bus.cpu_reset !== 1'b1 || bus.load_ready !== 1'b0 || bus.mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_ctrl: cpu_reset=%b load_ready=%b mem_we=%b want 1/0/0",
               bus.cpu_reset, bus.load_ready, bus.mem_we);
    end
    n_tests++;
    if (bus.dbg_state !== S_WAIT || bus.overflow !== 1'b0 || bus.checksum !== 32'd0) begin
      n_fail++;
      $display("FAIL midrst_status: state=%0d overflow=%b checksum=%h want 0/0/0",
               bus.dbg_state, bus.overflow, bus.checksum);
    end
    bus.load_valid = 1'b0;
    bus.load_data  = 32'd0;
    tick();
    n_tests++;
    if (mem[0] !== 32'hA0 || mem[1] !== 32'hA1 || mem[2] !== 32'hB2) begin
      n_fail++;
      $display("FAIL midrst_mem: mem0=%h mem1=%h mem2=%h want a0/a1/b2", mem[0], mem[1], mem[2]);
    end
    // Load request held through reset release: WAIT goes straight to LOAD.
    bus.load_req = 1'b1;
    reset_n = 1'b1;
    rst_ok = 1'b1;
    for (int i = 0; i < 10 && bus.dbg_state !== S_LOAD; i++) begin
      tick();
      if (bus.cpu_reset !== 1'b1) rst_ok = 1'b0;
    end
    bus.load_req = 1'b0;
    n_tests++;
    if (bus.dbg_state !== S_LOAD || !rst_ok) begin
      n_fail++;
      $display("FAIL wait_to_load: state=%0d cpu_reset_ok=%b want 2/1", bus.dbg_state, rst_ok);
    end
    send_word(32'h77, 1'b1);
    for (int i = 0; i < 20 && bus.dbg_state !== S_RUN; i++) tick();
    n_tests++;
    if (bus.dbg_state !== S_RUN || mem[0] !== 32'h77) begin
      n_fail++;
      $display("FAIL final_run: state=%0d mem[0]=%h want 1/77", bus.dbg_state, mem[0]);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < 16; i++) mem[i] = 32'd0;
    mem[5] = 32'hCAFE0005;
    reset_n          = 1'b0;
    bus.load_req     = 1'b0;
    bus.load_valid   = 1'b0;
    bus.load_data    = 32'd0;
    bus.load_last    = 1'b0;
    bus.cpu_rom_addr = 4'd0;
    test_reset();
    test_power_on();
    test_load_basic();
    test_overflow();
    test_gapped();
    test_reset_mid_load();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
